// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: the master drives load/start/stop/tick
// controls and the slave (the timer) returns count, busy and done.
interface countdown_timer_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             ld;
  logic [WIDTH-1:0] v;
  logic             start;
  logic             stop;
  logic             auto_rl;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output en, ld, v, start, stop, auto_rl,
    input  count, busy, done
  );

  modport slave (
    input  en, ld, v, start, stop, auto_rl,
    output count, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/stop control, optional auto-reload and a
// one-cycle done pulse in the cycle the count reaches its terminal value.
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  countdown_timer_if.slave  bus
);
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_busy;
  logic             r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.ld) begin
        r_count  <= bus.v;
        r_reload <= bus.v;
        r_state  <= S_IDLE;
        r_busy   <= 1'b0;
      end else if (bus.stop) begin
        // A stop in IDLE is swallowed here so a simultaneous start is ignored too.
        if (r_state == S_RUN) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      end else if (bus.start && r_state == S_IDLE) begin
        if (r_count != '0) begin
          r_state <= S_RUN;
          r_busy  <= 1'b1;
        end else begin
          r_done <= 1'b1;
        end
      end else if (r_state == S_RUN && bus.en) begin
        if (r_count > C_ONE) begin
          r_count <= r_count - C_ONE;
        end else if (r_count == C_ONE) begin
          r_done <= 1'b1;
          // A zero reload would spin forever, so it terminates like non-auto mode.
          if (bus.auto_rl && r_reload != '0) begin
            r_count <= r_reload;
          end else begin
            r_count <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end else begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      end
    end
  end

  assign bus.count = r_count;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: hand-computed count/busy/done after each edge.
module tb_countdown_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  countdown_timer_if #(.WIDTH(8)) bus();

  countdown_timer #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input int b, input int d);
    chk({tag, ".count"}, 32'(bus.count), 32'(c));
    chk({tag, ".busy"},  32'(bus.busy),  32'(b));
    chk({tag, ".done"},  32'(bus.done),  32'(d));
    $display("%t %s count=%0d busy=%0b done=%0b", $time, tag, bus.count, bus.busy, bus.done);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_c[$];
    int exp_d[$];
    bus.en = 1'b0; bus.ld = 1'b0; bus.v = 8'd0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.auto_rl = 1'b0;
    #2;
    chk_all("reset", 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic countdown from 5, auto off
    bus.ld = 1'b1; bus.v = 8'd5; tick(); bus.ld = 1'b0;
    chk_all("load5", 5, 0, 0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk_all("start5", 5, 1, 0);
    bus.en = 1'b1;
    for (int k = 4; k >= 1; k--) begin
      tick(); chk_all("dec5", k, 1, 0);
    end
    tick(); chk_all("term5", 0, 0, 1);
    tick(); chk_all("hold0", 0, 0, 0);

    // Auto-reload from 3, start in RUN ignored
    bus.en = 1'b0; bus.auto_rl = 1'b1;
    bus.ld = 1'b1; bus.v = 8'd3; tick(); bus.ld = 1'b0;
    bus.start = 1'b1; tick();
    chk_all("start3", 3, 1, 0);
    bus.en = 1'b1;
    exp_c = '{2, 1, 3, 2, 1, 3};
    exp_d = '{0, 0, 1, 0, 0, 1};
    for (int k = 0; k < 6; k++) begin
      tick(); chk_all("auto3", exp_c[k], 1, exp_d[k]);
    end
    bus.start = 1'b0;
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    chk_all("stopauto", 3, 0, 0);
    bus.auto_rl = 1'b0;

    // en toggling: only en=1 cycles count
    bus.en = 1'b0;
    bus.ld = 1'b1; bus.v = 8'd4; tick(); bus.ld = 1'b0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk_all("start4", 4, 1, 0);
    exp_c = '{3, 3, 2, 2, 1, 1, 0, 0};
    exp_d = '{0, 0, 0, 0, 0, 0, 1, 0};
    for (int k = 0; k < 8; k++) begin
      bus.en = (k % 2 == 0);
      tick(); chk_all("toggle4", exp_c[k], (k < 6) ? 1 : 0, exp_d[k]);
    end

    // Stop mid-run, hold, resume
    bus.en = 1'b0;
    bus.ld = 1'b1; bus.v = 8'd10; tick(); bus.ld = 1'b0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.en = 1'b1;
    tick(); tick(); tick();
    chk_all("run10", 7, 1, 0);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    chk_all("stop7", 7, 0, 0);
    tick(); chk_all("idlehold7", 7, 0, 0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk_all("resume7", 7, 1, 0);
    tick(); chk_all("resume6", 6, 1, 0);

    // ld beats stop in RUN
    bus.ld = 1'b1; bus.stop = 1'b1; bus.v = 8'd2; tick();
    bus.ld = 1'b0; bus.stop = 1'b0;
    chk_all("ldstop", 2, 0, 0);

    // Auto with reload 1: done every en cycle
    bus.auto_rl = 1'b1;
    bus.ld = 1'b1; bus.v = 8'd1; tick(); bus.ld = 1'b0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(); chk_all("reload1", 1, 1, 1);
    end
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    chk_all("stopr1", 1, 0, 0);
    bus.auto_rl = 1'b0; bus.en = 1'b0;

    // Start with count 0 after reset
    #2 rst = 1'b1; #1 rst = 1'b0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk_all("start0", 0, 0, 1);
    tick(); chk_all("start0b", 0, 0, 0);

    // Async reset mid-run
    bus.ld = 1'b1; bus.v = 8'd3; tick(); bus.ld = 1'b0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.en = 1'b1; tick();
    chk_all("prerst", 2, 1, 0);
    #2 rst = 1'b1; #1;
    chk_all("asyncrst", 0, 0, 0);
    tick(); rst = 1'b0;
    tick(); chk_all("postrst1", 0, 0, 0);
    tick(); chk_all("postrst2", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
